// File: rtl/multicycle_control.sv
// Multicycle MIPS-subset control FSM: sequences fetch/decode/execute and
// drives the datapath strobes/selects for lw, sw, R-type, beq, j, addi.
//
// Ports:
//   clk           rising-edge clock
//   rst_n         synchronous active-low reset; gates every output but state
//   opcode        instruction[31:26], sampled in DECODE and MEMADR only
//   mem_ready     memory access completes this cycle
//   pc_write .. alu_src_a   1-bit datapath strobes/selects
//   alu_src_b     00 B, 01 const 4, 10 imm, 11 imm<<2
//   alu_op        00 add, 01 sub, 10 funct
//   pc_source     00 ALU, 01 ALUOut, 10 jump target
//   state         current state (debug)
//   instr_done    pulse on the last cycle of each instruction
//   illegal_op    pulse on an unsupported opcode
module multicycle_control #(
  parameter int MEM_HANDSHAKE = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic       i_or_d,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       mem_to_reg,
  output logic       reg_dst,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [1:0] pc_source,
  output logic [3:0] state,
  output logic       instr_done,
  output logic       illegal_op
);

  localparam logic [3:0] S_FETCH  = 4'd0;
  localparam logic [3:0] S_DECODE = 4'd1;
  localparam logic [3:0] S_MEMADR = 4'd2;
  localparam logic [3:0] S_MEMRD  = 4'd3;
  localparam logic [3:0] S_MEMWB  = 4'd4;
  localparam logic [3:0] S_MEMWR  = 4'd5;
  localparam logic [3:0] S_EXEC   = 4'd6;
  localparam logic [3:0] S_ALUWB  = 4'd7;
  localparam logic [3:0] S_BRANCH = 4'd8;
  localparam logic [3:0] S_JUMP   = 4'd9;
  localparam logic [3:0] S_ADDIEX = 4'd10;
  localparam logic [3:0] S_ADDIWB = 4'd11;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
    logic       instr_done;
    logic       illegal_op;
  } ctl_t;

  logic [3:0] state_q;
  logic [3:0] state_d;
  ctl_t       c;
  logic       rdy;

  logic is_lw;
  logic is_sw;
  logic is_r;
  logic is_beq;
  logic is_j;
  logic is_addi;

  // Without handshake every memory state completes in one cycle.
  assign rdy = (MEM_HANDSHAKE != 0) ? mem_ready : 1'b1;

  assign is_lw   = (opcode == 6'b100011);
  assign is_sw   = (opcode == 6'b101011);
  assign is_r    = (opcode == 6'b000000);
  assign is_beq  = (opcode == 6'b000100);
  assign is_j    = (opcode == 6'b000010);
  assign is_addi = (opcode == 6'b001000);

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= S_FETCH;
    else        state_q <= state_d;
  end

  always_comb begin
    c       = '0;
    state_d = state_q;
    unique case (state_q)
      S_FETCH: begin
        c.mem_read  = 1'b1;
        c.alu_src_b = 2'b01;
        c.ir_write  = rdy;
        c.pc_write  = rdy;
        if (rdy) state_d = S_DECODE;
      end
      S_DECODE: begin
        c.alu_src_b = 2'b11;
        unique case (1'b1)
          is_lw, is_sw: state_d = S_MEMADR;
          is_r:         state_d = S_EXEC;
          is_beq:       state_d = S_BRANCH;
          is_j:         state_d = S_JUMP;
          is_addi:      state_d = S_ADDIEX;
          default: begin
            c.illegal_op = 1'b1;
            c.instr_done = 1'b1;
            state_d      = S_FETCH;
          end
        endcase
      end
      S_MEMADR: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = 2'b10;
        state_d     = is_lw ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        c.mem_read = 1'b1;
        c.i_or_d   = 1'b1;
        if (rdy) state_d = S_MEMWB;
      end
      S_MEMWB: begin
        c.mem_to_reg = 1'b1;
        c.reg_write  = 1'b1;
        c.instr_done = 1'b1;
        state_d      = S_FETCH;
      end
      S_MEMWR: begin
        c.mem_write  = 1'b1;
        c.i_or_d     = 1'b1;
        c.instr_done = rdy;
        if (rdy) state_d = S_FETCH;
      end
      S_EXEC: begin
        c.alu_src_a = 1'b1;
        c.alu_op    = 2'b10;
        state_d     = S_ALUWB;
      end
      S_ALUWB: begin
        c.reg_dst    = 1'b1;
        c.reg_write  = 1'b1;
        c.instr_done = 1'b1;
        state_d      = S_FETCH;
      end
      S_BRANCH: begin
        c.alu_src_a     = 1'b1;
        c.alu_op        = 2'b01;
        c.pc_write_cond = 1'b1;
        c.pc_source     = 2'b01;
        c.instr_done    = 1'b1;
        state_d         = S_FETCH;
      end
      S_JUMP: begin
        c.pc_write   = 1'b1;
        c.pc_source  = 2'b10;
        c.instr_done = 1'b1;
        state_d      = S_FETCH;
      end
      S_ADDIEX: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = 2'b10;
        state_d     = S_ADDIWB;
      end
      S_ADDIWB: begin
        c.reg_write  = 1'b1;
        c.instr_done = 1'b1;
        state_d      = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase
  end

  assign state = state_q;

  // Reset masks the strobes immediately, even mid memory wait.
  assign {pc_write, pc_write_cond, i_or_d, mem_read,
          mem_write, ir_write, mem_to_reg, reg_dst,
          reg_write, alu_src_a, alu_src_b, alu_op,
          pc_source, instr_done, illegal_op}
         = rst_n ? c : '0;

endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench for multicycle_control: per-cycle expected control
// words queued at drive time, popped and compared on the falling edge.
module tb_multicycle_control;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst0_n;
  logic       rst1_n;
  logic [5:0] opcode;
  logic       mem_ready;

  logic pcw0, pwc0, iod0, mrd0, mwr0, irw0, m2r0, rdst0, rw0, asa0;
  logic pcw1, pwc1, iod1, mrd1, mwr1, irw1, m2r1, rdst1, rw1, asa1;
  logic [1:0] asb0, aop0, psrc0, asb1, aop1, psrc1;
  logic [3:0] st0, st1;
  logic done0, ill0, done1, ill1;

  multicycle_control #(.MEM_HANDSHAKE(1)) u_hs (
    .clk(clk), .rst_n(rst0_n), .opcode(opcode),
    .mem_ready(mem_ready),
    .pc_write(pcw0), .pc_write_cond(pwc0),
    .i_or_d(iod0), .mem_read(mrd0), .mem_write(mwr0),
    .ir_write(irw0), .mem_to_reg(m2r0), .reg_dst(rdst0),
    .reg_write(rw0), .alu_src_a(asa0), .alu_src_b(asb0),
    .alu_op(aop0), .pc_source(psrc0), .state(st0),
    .instr_done(done0), .illegal_op(ill0)
  );

  multicycle_control #(.MEM_HANDSHAKE(0)) u_nohs (
    .clk(clk), .rst_n(rst1_n), .opcode(opcode),
    .mem_ready(mem_ready),
    .pc_write(pcw1), .pc_write_cond(pwc1),
    .i_or_d(iod1), .mem_read(mrd1), .mem_write(mwr1),
    .ir_write(irw1), .mem_to_reg(m2r1), .reg_dst(rdst1),
    .reg_write(rw1), .alu_src_a(asa1), .alu_src_b(asb1),
    .alu_op(aop1), .pc_source(psrc1), .state(st1),
    .instr_done(done1), .illegal_op(ill1)
  );

  logic [21:0] obs0, obs1;
  assign obs0 = {st0, pcw0, pwc0, iod0, mrd0, mwr0, irw0,
                 m2r0, rdst0, rw0, asa0, asb0, aop0, psrc0,
                 done0, ill0};
  assign obs1 = {st1, pcw1, pwc1, iod1, mrd1, mwr1, irw1,
                 m2r1, rdst1, rw1, asa1, asb1, aop1, psrc1,
                 done1, ill1};

  // strobe bits, order pc_write .. alu_src_a
  localparam logic [9:0] PCW  = 10'b1000000000;
  localparam logic [9:0] PWC  = 10'b0100000000;
  localparam logic [9:0] IOD  = 10'b0010000000;
  localparam logic [9:0] MRD  = 10'b0001000000;
  localparam logic [9:0] MWR  = 10'b0000100000;
  localparam logic [9:0] IRW  = 10'b0000010000;
  localparam logic [9:0] M2R  = 10'b0000001000;
  localparam logic [9:0] RDST = 10'b0000000100;
  localparam logic [9:0] RW   = 10'b0000000010;
  localparam logic [9:0] ASA  = 10'b0000000001;

  // {state, strobes, asb, aop, psrc, done, ill}
  localparam logic [21:0] E_FETCH =
    {4'd0, PCW | MRD | IRW, 2'b01, 2'b00, 2'b00, 2'b00};
  localparam logic [21:0] E_FWAIT =
    {4'd0, MRD, 2'b01, 2'b00, 2'b00, 2'b00};
  localparam logic [21:0] E_DEC =
    {4'd1, 10'd0, 2'b11, 2'b00, 2'b00, 2'b00};
  localparam logic [21:0] E_ILL =
    {4'd1, 10'd0, 2'b11, 2'b00, 2'b00, 2'b11};
  localparam logic [21:0] E_MADR =
    {4'd2, ASA, 2'b10, 2'b00, 2'b00, 2'b00};
  localparam logic [21:0] E_MRD =
    {4'd3, MRD | IOD, 2'b00, 2'b00, 2'b00, 2'b00};
  localparam logic [21:0] E_MWB =
    {4'd4, M2R | RW, 2'b00, 2'b00, 2'b00, 2'b10};
  localparam logic [21:0] E_MWRW =
    {4'd5, MWR | IOD, 2'b00, 2'b00, 2'b00, 2'b00};
  localparam logic [21:0] E_MWR =
    {4'd5, MWR | IOD, 2'b00, 2'b00, 2'b00, 2'b10};
  localparam logic [21:0] E_EXEC =
    {4'd6, ASA, 2'b00, 2'b10, 2'b00, 2'b00};
  localparam logic [21:0] E_AWB =
    {4'd7, RDST | RW, 2'b00, 2'b00, 2'b00, 2'b10};
  localparam logic [21:0] E_BR =
    {4'd8, ASA | PWC, 2'b00, 2'b01, 2'b01, 2'b10};
  localparam logic [21:0] E_JMP =
    {4'd9, PCW, 2'b00, 2'b00, 2'b10, 2'b10};
  localparam logic [21:0] E_AEX =
    {4'd10, ASA, 2'b10, 2'b00, 2'b00, 2'b00};
  localparam logic [21:0] E_AIWB =
    {4'd11, RW, 2'b00, 2'b00, 2'b00, 2'b10};

  int n_cmp = 0;
  int n_bad = 0;

  logic [21:0] q0[$];
  logic [21:0] q1[$];
  string       t0[$];
  string       t1[$];

  task automatic check(input string tag,
                       input logic [21:0] got,
                       input logic [21:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (q0.size() > 0) begin
      check(t0.pop_front(), obs0, q0.pop_front());
      check("hs_excl", 22'({mrd0 & mwr0, rw0 & mwr0}), 22'd0);
    end
    if (q1.size() > 0) begin
      check(t1.pop_front(), obs1, q1.pop_front());
      check("nohs_excl", 22'({mrd1 & mwr1, rw1 & mwr1}), 22'd0);
    end
  end

  task automatic cyc(input string tag, input logic [5:0] op,
                     input logic mr, input logic r0,
                     input logic r1, input logic [21:0] x0,
                     input logic [21:0] x1);
    opcode    = op;
    mem_ready = mr;
    rst0_n    = r0;
    rst1_n    = r1;
    q0.push_back(x0);
    t0.push_back({"hs.", tag});
    q1.push_back(x1);
    t1.push_back({"nohs.", tag});
    @(posedge clk);
    #1;
  endtask

  // handshake instance active, other held in reset
  task automatic c0(input string tag, input logic [5:0] op,
                    input logic mr, input logic r0,
                    input logic [21:0] x0);
    cyc(tag, op, mr, r0, 1'b0, x0, 22'd0);
  endtask

  // no-handshake instance active, other held in reset
  task automatic c1(input string tag, input logic [5:0] op,
                    input logic [21:0] x1);
    cyc(tag, op, 1'b0, 1'b0, 1'b1, 22'd0, x1);
  endtask

  initial begin
    rst0_n    = 1'b0;
    rst1_n    = 1'b0;
    opcode    = 6'h00;
    mem_ready = 1'b1;
    @(posedge clk);
    #1;
    c0("rst", 6'h00, 1'b1, 1'b0, 22'd0);
    // R-type: 0,1,6,7
    c0("r.fetch", 6'h00, 1'b1, 1'b1, E_FETCH);
    c0("r.dec",   6'h00, 1'b1, 1'b1, E_DEC);
    c0("r.exec",  6'h00, 1'b1, 1'b1, E_EXEC);
    c0("r.wb",    6'h00, 1'b1, 1'b1, E_AWB);
    // lw with fetch wait and three MEMRD wait cycles
    c0("lw.fwait", 6'h23, 1'b0, 1'b1, E_FWAIT);
    c0("lw.fetch", 6'h23, 1'b1, 1'b1, E_FETCH);
    c0("lw.dec",   6'h23, 1'b1, 1'b1, E_DEC);
    c0("lw.adr",   6'h23, 1'b0, 1'b1, E_MADR);
    for (int i = 0; i < 3; i++)
      c0("lw.rdwait", 6'h00, 1'b0, 1'b1, E_MRD);
    c0("lw.rd",    6'h00, 1'b1, 1'b1, E_MRD);
    c0("lw.wb",    6'h00, 1'b1, 1'b1, E_MWB);
    // sw with one write wait
    c0("sw.fetch", 6'h2b, 1'b1, 1'b1, E_FETCH);
    c0("sw.dec",   6'h2b, 1'b1, 1'b1, E_DEC);
    c0("sw.adr",   6'h2b, 1'b1, 1'b1, E_MADR);
    c0("sw.wrwait", 6'h23, 1'b0, 1'b1, E_MWRW);
    c0("sw.wr",    6'h23, 1'b1, 1'b1, E_MWR);
    // beq, j, addi, illegal
    c0("beq.fetch", 6'h04, 1'b1, 1'b1, E_FETCH);
    c0("beq.dec",   6'h04, 1'b1, 1'b1, E_DEC);
    c0("beq.br",    6'h04, 1'b1, 1'b1, E_BR);
    c0("j.fetch",   6'h02, 1'b1, 1'b1, E_FETCH);
    c0("j.dec",     6'h02, 1'b1, 1'b1, E_DEC);
    c0("j.jmp",     6'h02, 1'b1, 1'b1, E_JMP);
    c0("addi.fetch", 6'h08, 1'b1, 1'b1, E_FETCH);
    c0("addi.dec",   6'h08, 1'b1, 1'b1, E_DEC);
    c0("addi.ex",    6'h08, 1'b1, 1'b1, E_AEX);
    c0("addi.wb",    6'h08, 1'b1, 1'b1, E_AIWB);
    c0("ill.fetch", 6'h3f, 1'b1, 1'b1, E_FETCH);
    c0("ill.dec",   6'h3f, 1'b1, 1'b1, E_ILL);
    // opcode only matters in DECODE
    c0("samp.fetch", 6'h3f, 1'b1, 1'b1, E_FETCH);
    c0("samp.dec",   6'h00, 1'b1, 1'b1, E_DEC);
    c0("samp.exec",  6'h3f, 1'b1, 1'b1, E_EXEC);
    c0("samp.wb",    6'h3f, 1'b1, 1'b1, E_AWB);
    // reset during MEMWR wait
    c0("rwr.fetch", 6'h2b, 1'b1, 1'b1, E_FETCH);
    c0("rwr.dec",   6'h2b, 1'b1, 1'b1, E_DEC);
    c0("rwr.adr",   6'h2b, 1'b1, 1'b1, E_MADR);
    c0("rwr.wait",  6'h2b, 1'b0, 1'b1, E_MWRW);
    c0("rwr.rst",   6'h2b, 1'b0, 1'b0, {4'd5, 18'd0});
    c0("rwr.after", 6'h23, 1'b1, 1'b1, E_FETCH);
    // reset during MEMRD wait
    c0("rrd.dec",   6'h23, 1'b1, 1'b1, E_DEC);
    c0("rrd.adr",   6'h23, 1'b1, 1'b1, E_MADR);
    c0("rrd.wait",  6'h23, 1'b0, 1'b1, E_MRD);
    c0("rrd.rst",   6'h23, 1'b1, 1'b0, {4'd3, 18'd0});
    c0("rrd.after", 6'h23, 1'b1, 1'b1, E_FETCH);
    c0("hs.park",   6'h23, 1'b1, 1'b0, {4'd1, 18'd0});
    // no handshake, mem_ready stuck low
    c1("sw.fetch", 6'h2b, E_FETCH);
    c1("sw.dec",   6'h2b, E_DEC);
    c1("sw.adr",   6'h2b, E_MADR);
    c1("sw.wr",    6'h2b, E_MWR);
    c1("lw.fetch", 6'h23, E_FETCH);
    c1("lw.dec",   6'h23, E_DEC);
    c1("lw.adr",   6'h23, E_MADR);
    c1("lw.rd",    6'h23, E_MRD);
    c1("lw.wb",    6'h23, E_MWB);
    c1("end.fetch", 6'h00, E_FETCH);
    check("q_drain", 22'(q0.size() + q1.size()), 22'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
